// File: rtl/block_spawn_sequencer.sv
// Level-based falling-block spawn sequencer: staggered block launches, level completion, level gaps and a seconds counter.
// Optional pause-on-Run while busy is enabled with `define BLOCK_SPAWN_PAUSE_EN.
module block_spawn_sequencer #(
    parameter int NUM_BLOCKS   = 10,
    parameter int NUM_LEVELS   = 2,
    parameter int CLK_HZ       = 50000000,
    parameter int SPAWN_CYCLES = 25000000,
    parameter int GAP_CYCLES   = 50000000,
    parameter int SEC_W        = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Run,
    input  logic [NUM_BLOCKS-1:0] end_level,
    output logic [NUM_BLOCKS-1:0] block_ready,
    output logic [NUM_LEVELS-1:0] level_onehot,
    output logic [SEC_W-1:0]      seconds,
    output logic                  busy,
    output logic                  game_done,
    output logic                  paused
);

    localparam int IDX_W   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int LVL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int SPAWN_W = $clog2(SPAWN_CYCLES + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int PRE_W   = $clog2(CLK_HZ + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = (NUM_BLOCKS > 1) ? IDX_W'(1) : IDX_W'(0);
    localparam logic [LVL_W-1:0] LAST_LVL  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_HZ - 1);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        WAIT_CLEAR,
        LEVEL_GAP,
        DONE
    } state_t;

    state_t             state;
    logic               run_q;
    logic               run_rise;
    logic               pause_toggle;
    logic [LVL_W-1:0]   level;
    logic [IDX_W-1:0]   next_idx;
    logic [SPAWN_W-1:0] spawn_cnt;
    logic [SPAWN_W-1:0] spawn_last;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PRE_W-1:0]   prescale;

    // Spawn interval halves each level but never drops below one cycle.
    function automatic logic [SPAWN_W-1:0] spawn_last_of(input logic [LVL_W-1:0] lvl);
        int unsigned iv;
        iv = unsigned'(SPAWN_CYCLES) >> lvl;
        if (iv == 0) iv = 1;
        return SPAWN_W'(iv - 1);
    endfunction

    assign spawn_last = spawn_last_of(level);
    assign run_rise   = Run & ~run_q;

`ifdef BLOCK_SPAWN_PAUSE_EN
    assign pause_toggle = busy & run_rise;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)             paused <= 1'b0;
        else if (pause_toggle) paused <= ~paused;
    end
`else
    assign pause_toggle = 1'b0;
    assign paused       = 1'b0;
`endif

    // NOTE: every register in this block uses <= so all updates see pre-edge values,
    // which keeps counters, state and outputs consistent within one clock edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            run_q        <= 1'b0;
            level        <= '0;
            next_idx     <= '0;
            spawn_cnt    <= '0;
            gap_cnt      <= '0;
            prescale     <= '0;
            block_ready  <= '0;
            level_onehot <= '0;
            seconds      <= '0;
            busy         <= 1'b0;
            game_done    <= 1'b0;
        end else begin
            run_q <= Run;

            if (busy && !paused) begin
                if (prescale == PRE_LAST) begin
                    prescale <= '0;
                    if (seconds != '1) seconds <= seconds + 1'b1;
                end else begin
                    prescale <= prescale + 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (run_rise) begin
                        level        <= '0;
                        seconds      <= '0;
                        prescale     <= '0;
                        spawn_cnt    <= '0;
                        next_idx     <= FIRST_IDX;
                        block_ready  <= NUM_BLOCKS'(1);
                        level_onehot <= NUM_LEVELS'(1);
                        busy         <= 1'b1;
                        game_done    <= 1'b0;
                        state        <= (NUM_BLOCKS == 1) ? WAIT_CLEAR : SPAWN;
                    end
                end

                SPAWN: begin
                    if (!paused) begin
                        if (spawn_cnt == spawn_last) begin
                            spawn_cnt             <= '0;
                            block_ready[next_idx] <= 1'b1;
                            next_idx              <= next_idx + 1'b1;
                            if (next_idx == LAST_IDX) state <= WAIT_CLEAR;
                        end else begin
                            spawn_cnt <= spawn_cnt + 1'b1;
                        end
                    end
                end

                WAIT_CLEAR: begin
                    // A pause toggle on the same edge wins over level completion.
                    if (!paused && !pause_toggle && (&end_level)) begin
                        block_ready <= '0;
                        if (level == LAST_LVL) begin
                            state        <= DONE;
                            level_onehot <= '0;
                            busy         <= 1'b0;
                            game_done    <= 1'b1;
                        end else begin
                            state   <= LEVEL_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end

                LEVEL_GAP: begin
                    if (!paused) begin
                        if (gap_cnt == GAP_LAST) begin
                            level        <= level + 1'b1;
                            level_onehot <= level_onehot << 1;
                            spawn_cnt    <= '0;
                            next_idx     <= FIRST_IDX;
                            block_ready  <= NUM_BLOCKS'(1);
                            state        <= (NUM_BLOCKS == 1) ? WAIT_CLEAR : SPAWN;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_spawn_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized stimulus vs a timestamp-based model.
module tb_block_spawn_sequencer;

    localparam int NB  = 4;
    localparam int NL  = 2;
    localparam int CHZ = 10;
    localparam int SPW = 8;
    localparam int GAP = 4;
    localparam int SW  = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Run;
    logic [NB-1:0] end_level;
    logic [NB-1:0] block_ready;
    logic [NL-1:0] level_onehot;
    logic [SW-1:0] seconds;
    logic          busy;
    logic          game_done;
    logic          paused;

    block_spawn_sequencer #(
        .NUM_BLOCKS(NB), .NUM_LEVELS(NL), .CLK_HZ(CHZ),
        .SPAWN_CYCLES(SPW), .GAP_CYCLES(GAP), .SEC_W(SW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .end_level(end_level),
        .block_ready(block_ready), .level_onehot(level_onehot), .seconds(seconds),
        .busy(busy), .game_done(game_done), .paused(paused)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase plus elapsed edges in that phase; outputs derived arithmetically.
    typedef enum {M_IDLE, M_SPAWN, M_WAIT, M_GAP, M_DONE} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_level = 0;
    int      m_t     = 0;
    int      m_busy_edges = 0;
    bit      m_run_prev = 1'b0;
    bit      m_rise;

    function automatic int interval(input int k);
        int v;
        v = SPW >> k;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic bit m_is_busy();
        return (m_phase == M_SPAWN) || (m_phase == M_WAIT) || (m_phase == M_GAP);
    endfunction

    function automatic logic [NB-1:0] exp_br();
        logic [NB-1:0] r;
        r = '0;
        if (m_phase == M_WAIT) r = '1;
        else if (m_phase == M_SPAWN)
            for (int i = 0; i < NB; i++)
                if (i * interval(m_level) <= m_t) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int exp_sec();
        int s;
        s = m_busy_edges / CHZ;
        return (s > (1 << SW) - 1) ? (1 << SW) - 1 : s;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_phase = M_IDLE; m_level = 0; m_t = 0; m_busy_edges = 0; m_run_prev = 1'b0;
        end else begin
            m_rise     = Run && !m_run_prev;
            m_run_prev = Run;
            if (m_is_busy()) m_busy_edges++;
            case (m_phase)
                M_IDLE, M_DONE: if (m_rise) begin
                    m_level = 0; m_t = 0; m_busy_edges = 0;
                    m_phase = (NB == 1) ? M_WAIT : M_SPAWN;
                end
                M_SPAWN: begin
                    m_t++;
                    if (m_t == (NB - 1) * interval(m_level)) begin m_phase = M_WAIT; m_t = 0; end
                end
                M_WAIT: if (end_level == '1)
                    if (m_level == NL - 1) m_phase = M_DONE;
                    else begin m_phase = M_GAP; m_t = 0; end
                M_GAP: begin
                    m_t++;
                    if (m_t == GAP) begin m_level++; m_t = 0; m_phase = (NB == 1) ? M_WAIT : M_SPAWN; end
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (cmp_en && !Reset) begin
            check("block_ready",  32'(block_ready),  32'(exp_br()));
            check("level_onehot", 32'(level_onehot), m_is_busy() ? (32'd1 << m_level) : 32'd0);
            check("seconds",      32'(seconds),      32'(exp_sec()));
            check("busy",         32'(busy),         32'(m_is_busy()));
            check("game_done",    32'(game_done),    32'(m_phase == M_DONE));
            check("paused",       32'(paused),       32'd0);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; end_level = '0;
        repeat (3) step();
        check("rst_block_ready", 32'(block_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_seconds", 32'(seconds), 32'd0);
        Reset = 1'b0;
        cmp_en = 1'b1;
        step();

        // Level 0 spawning: one bit every 8 cycles from start edge T
        Run = 1'b1;
        step();
        check("T_br", 32'(block_ready), 32'h1);
        check("T_onehot", 32'(level_onehot), 32'h1);
        check("T_busy", 32'(busy), 32'd1);
        repeat (7) step();
        check("T7_br", 32'(block_ready), 32'h1);
        step();
        check("T8_br", 32'(block_ready), 32'h3);
        repeat (8) step();
        check("T16_br", 32'(block_ready), 32'h7);
        repeat (8) step();
        check("T24_br", 32'(block_ready), 32'hF);

        // Level 0 completion, gap, then level 1 at 4-cycle spacing
        end_level = '1;
        step();
        check("T25_br", 32'(block_ready), 32'h0);
        end_level = '0;
        repeat (3) step();
        check("T28_onehot", 32'(level_onehot), 32'h1);
        step();
        check("T29_onehot", 32'(level_onehot), 32'h2);
        check("T29_br", 32'(block_ready), 32'h1);
        repeat (4) step();
        check("T33_br", 32'(block_ready), 32'h3);
        repeat (8) step();
        check("T41_br", 32'(block_ready), 32'hF);
        end_level = '1;
        step();
        check("T42_done", 32'(game_done), 32'd1);
        check("T42_busy", 32'(busy), 32'd0);
        check("T42_onehot", 32'(level_onehot), 32'h0);
        check("T42_seconds", 32'(seconds), 32'd4);

        // Held Run does not restart; a fresh press does
        repeat (100) step();
        check("held_done", 32'(game_done), 32'd1);
        check("held_seconds", 32'(seconds), 32'd4);
        end_level = '0; Run = 1'b0;
        step();
        Run = 1'b1;
        step();
        check("restart_seconds", 32'(seconds), 32'd0);
        check("restart_br", 32'(block_ready), 32'h1);
        check("restart_done", 32'(game_done), 32'd0);

        // Seconds saturation with Run held, no extra spawns
        repeat (200) step();
        check("sat_seconds", 32'(seconds), 32'd15);
        check("sat_br", 32'(block_ready), 32'hF);
        check("sat_busy", 32'(busy), 32'd1);

        // Asynchronous reset mid-SPAWN
        Run = 1'b0; Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        Run = 1'b1;
        step();
        repeat (10) step();
        check("pre_rst_br", 32'(block_ready), 32'h3);
        Reset = 1'b1;
        #1;
        check("async_rst_br", 32'(block_ready), 32'h0);
        check("async_rst_onehot", 32'(level_onehot), 32'h0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_seconds", 32'(seconds), 32'd0);
        step();
        Reset = 1'b0; Run = 1'b0;
        step();

        // Randomized phase against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) Run = ~Run;
            end_level = ($urandom_range(0, 2) == 0) ? '1 : NB'($urandom);
            Reset = ($urandom_range(0, 599) == 0);
            step();
        end
        Reset = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_spawn_sequencer.md
Name: block_spawn_sequencer

Overview:
Parametrised successor to the single-purpose block state machine. Releases NUM_BLOCKS falling blocks one at a time at a level-dependent interval, waits for every block to report done, then advances through NUM_LEVELS levels with a shorter spawn interval each level. Drives the per-block block_ready launch flags, a one-hot level indication for color_mapper and a seconds counter for the HEX display. Sits between the top level (Run button, vs-clocked block instances) and the block/colour logic, clocked by the 50 MHz system clock.

Parameters:
NUM_BLOCKS, 10, number of block channels (1..32)
NUM_LEVELS, 2, number of levels (1..8)
CLK_HZ, 50000000, clock cycles per second tick
SPAWN_CYCLES, 25000000, level-0 spawn interval in cycles; level k uses max(1, SPAWN_CYCLES >> k)
GAP_CYCLES, 50000000, idle cycles between levels (>=1)
SEC_W, 10, width of seconds output

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous reset, active-high
Run  in  1  active-high start request (level, may be held; internally edge-detected)
end_level  in  NUM_BLOCKS  per-block done flags (synchronous to Clk)
block_ready  out  NUM_BLOCKS  sticky per-block launch flags
level_onehot  out  NUM_LEVELS  bit k high while level k active (SPAWN/WAIT_CLEAR/LEVEL_GAP of level k)
seconds  out  SEC_W  seconds since start, saturating
busy  out  1  high in SPAWN, WAIT_CLEAR, LEVEL_GAP
game_done  out  1  high in DONE
paused  out  1  pause indication (see Optional Feature)

Behaviour:
- Reset (Clk-asynchronous, active-high; Clk and Reset are the only clock/reset): state IDLE, block_ready=0, level_onehot=0, seconds=0, busy=0, game_done=0, paused=0, all counters 0, Run edge register 0. Reset mid-operation aborts immediately to these values.
- run_rise = Run & ~run_q; run_q registered every cycle.
- IDLE / DONE: on run_rise -> SPAWN, level=0, seconds=0, second prescaler=0, block_ready = one-hot bit 0 set on the same edge, spawn counter=0.
- SPAWN: spawn counter counts 0..interval(level)-1; on wrap, set next block_ready bit (index n, ascending). When bit NUM_BLOCKS-1 is set, the same edge enters WAIT_CLEAR. With NUM_BLOCKS=1, enter WAIT_CLEAR directly on the start edge.
- block_ready bits, once set, stay set until LEVEL_GAP entry, IDLE or reset.
- WAIT_CLEAR: when &end_level==1 (sampled at clock edge): if level==NUM_LEVELS-1 -> DONE (block_ready cleared, level_onehot cleared, game_done=1); else -> LEVEL_GAP, block_ready cleared, gap counter=0.
- end_level bits asserted during SPAWN are ignored for level completion until WAIT_CLEAR.
- LEVEL_GAP: after GAP_CYCLES cycles, level+1 and SPAWN with block_ready bit 0 set on that edge.
- seconds: prescaler counts CLK_HZ cycles while busy; on wrap seconds+1, saturating at 2^SEC_W-1; held in DONE, cleared only on start or reset.
- run_rise in SPAWN/WAIT_CLEAR/LEVEL_GAP is ignored (without feature).
- Simultaneous run_rise and level completion in WAIT_CLEAR: completion wins.
- All outputs registered; no combinational path from inputs to outputs.

Optional Feature:
Macro BLOCK_SPAWN_PAUSE_EN. Defined: run_rise while busy toggles paused; while paused, state, spawn/gap counters, second prescaler and seconds freeze, and end_level is ignored; a toggle takes priority over a simultaneous level completion. Undefined: paused tied 0, run_rise while busy ignored.

Test Plan:
(Params NUM_BLOCKS=4, NUM_LEVELS=2, CLK_HZ=10, SPAWN_CYCLES=8, GAP_CYCLES=4, SEC_W=4.)
1. Reset asserted mid-SPAWN with block_ready=4'b0011 -> all outputs 0 immediately (before next Clk edge), state IDLE.
2. Run rises, start edge T -> block_ready=0001 at T, 0011 at T+8, 0111 at T+16, 1111 at T+24, busy=1, level_onehot=01.
3. end_level=4'b1111 in WAIT_CLEAR -> next edge block_ready=0; after 4 gap cycles level_onehot=10, block_ready=0001, then bits spaced 4 cycles apart.
4. Level-1 completion -> game_done=1, busy=0, seconds frozen; hold Run high 100 cycles -> no restart; release and re-press -> restart with seconds=0.
5. Run held for 200 busy cycles -> seconds saturates at 15, with no extra spawns from the held Run.
6. With BLOCK_SPAWN_PAUSE_EN: press Run at T+10 -> paused=1, block_ready stays 0011 for 50 cycles; press again -> next bit appears 6 cycles later.
